// File: rtl/ook_burst_generator_pkg.sv
// Shared OOK definitions: transmitter state encoding and frame geometry.
// Intended to be reused by a future OOK receiver/decoder.
package ook_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/ook_burst_generator_if.sv
// Byte handshake plus valid/data sample stream of the OOK burst generator.
// The master side offers bytes and consumes samples; the generator is the slave.
interface ook_burst_generator_if #(
  parameter int SAMPLE_DATA_WIDTH = 8
);

  logic                                tx_valid;
  logic [7:0]                          tx_data;
  logic                                tx_ready;
  logic                                axiov;
  logic signed [SAMPLE_DATA_WIDTH-1:0] axiod;
  logic                                busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, axiov, axiod, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, axiov, axiod, busy
  );

endinterface

// File: rtl/ook_burst_generator_strobe.sv
// Free-running sample-rate divider; strobe is high during the terminal-count cycle.
module sample_strobe_gen #(
  parameter int CLKS_PER_SAMPLE = 4
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  localparam int CW = $clog2(CLKS_PER_SAMPLE);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == CW'(CLKS_PER_SAMPLE - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign strobe = (div_cnt == CW'(CLKS_PER_SAMPLE - 1));

endmodule

// File: rtl/ook_burst_generator.sv
// OOK burst transmitter: serializes a byte as START, D0..D7, STOP bit periods of
// square-wave carrier (on) or silence (off), one sample per divider strobe.
module ook_burst_generator
  import ook_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH   = 8,
  parameter int SAMPLES_PER_BIT     = 500,
  parameter int CLKS_PER_SAMPLE     = 4,
  parameter int CARRIER_HALF_PERIOD = 4,
  parameter int AMPLITUDE           = 64
) (
  input logic                  clk,
  input logic                  rst,
  ook_burst_generator_if.slave bus
);

  localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int PH_W  = (CARRIER_HALF_PERIOD > 1) ? $clog2(CARRIER_HALF_PERIOD) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic signed [SAMPLE_DATA_WIDTH-1:0] POS_AMP = SAMPLE_DATA_WIDTH'(AMPLITUDE);
  localparam logic signed [SAMPLE_DATA_WIDTH-1:0] NEG_AMP = -POS_AMP;

  tx_state_t                           state_q;
  tx_state_t                           state_d;
  logic                                strobe;
  logic                                accept;
  logic                                bit_done;
  logic                                carrier_on;
  logic [DATA_BITS-1:0]                shift_q;
  logic [IDX_W-1:0]                    bit_idx;
  logic [CNT_W-1:0]                    sample_cnt;
  logic [PH_W-1:0]                     ph_cnt;
  logic                                carrier_neg;
  logic signed [SAMPLE_DATA_WIDTH-1:0] sample_val;

  sample_strobe_gen #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .strobe(strobe)
  );

  assign accept   = bus.tx_valid && (state_q == IDLE);
  assign bit_done = strobe && (sample_cnt == CNT_W'(SAMPLES_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit boundaries fall on the strobe that emits the last sample of a bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_done) state_d = DATA;
      DATA:  if (bit_done && (bit_idx == IDX_W'(DATA_BITS - 1))) state_d = STOP;
      STOP:  if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_ready = (state_q == IDLE);
    bus.busy     = (state_q != IDLE);
    carrier_on   = 1'b0;
    case (state_q)
      START:   carrier_on = 1'b1;
      DATA:    carrier_on = shift_q[0];
      default: carrier_on = 1'b0;
    endcase
    sample_val = carrier_on ? (carrier_neg ? NEG_AMP : POS_AMP) : '0;
  end

  // Carrier phase keeps running through off bits so on-bits stay phase-continuous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.axiov   <= 1'b0;
      bus.axiod   <= '0;
      shift_q     <= '0;
      bit_idx     <= '0;
      sample_cnt  <= '0;
      ph_cnt      <= '0;
      carrier_neg <= 1'b0;
    end else begin
      bus.axiov <= strobe;
      if (strobe) begin
        bus.axiod <= sample_val;
      end
      if (accept) begin
        shift_q     <= bus.tx_data;
        bit_idx     <= '0;
        sample_cnt  <= '0;
        ph_cnt      <= '0;
        carrier_neg <= 1'b0;
      end else if (strobe && (state_q != IDLE)) begin
        if (ph_cnt == PH_W'(CARRIER_HALF_PERIOD - 1)) begin
          ph_cnt      <= '0;
          carrier_neg <= ~carrier_neg;
        end else begin
          ph_cnt <= ph_cnt + 1'b1;
        end
        sample_cnt <= bit_done ? '0 : sample_cnt + 1'b1;
        if (bit_done && (state_q == DATA)) begin
          shift_q <= shift_q >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule
